// File: rtl/i2c_slave_responder.sv
// I2C target responder: oversampled SCL/SDA, START/STOP detection, address match,
// write-byte receive with ACK and read-byte transmit from local tx_data.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADR   = 7'h68,
    parameter int         SYNC_STAGES = 2,
    parameter logic       NACK_WRITE  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       start_det,
    output logic       stop_det,
    output logic       addr_match,
    output logic       rw,
    output logic       nack_det,
    output logic       busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] WR_DATA  = 3'd3;
    localparam logic [2:0] WR_ACK   = 3'd4;
    localparam logic [2:0] RD_DATA  = 3'd5;
    localparam logic [2:0] RD_ACK   = 3'd6;
    localparam logic [2:0] IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_c, stop_c;
    logic [2:0]             state;
    logic [3:0]             cnt;
    logic [7:0]             shifter;

    // Idle bus is high, so sync flops reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_c  = scl_s & scl_d & ~sda_s & sda_d;
    assign stop_c   = scl_s & scl_d & sda_s & ~sda_d;

    // tx_data is consumed in the same cycle tx_req is high.
    assign tx_req = scl_fall & ~start_c & ~stop_c &
                    (((state == ADDR_ACK) & rw) | (state == RD_ACK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            shifter    <= 8'h00;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            addr_match <= 1'b0;
            rw         <= 1'b0;
            nack_det   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            rx_valid  <= 1'b0;
            nack_det  <= 1'b0;
            if (start_c) begin
                state      <= ADDR;
                cnt        <= 4'd0;
                addr_match <= 1'b0;
                sda_oe     <= 1'b0;
                busy       <= 1'b1;
                start_det  <= 1'b1;
            end else if (stop_c) begin
                state      <= IDLE;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
                busy       <= 1'b0;
                stop_det   <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shifter <= {shifter[6:0], sda_s};
                            cnt     <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            if (shifter[7:1] == SLAVE_ADR) begin
                                sda_oe     <= 1'b1;
                                rw         <= shifter[0];
                                addr_match <= 1'b1;
                                state      <= ADDR_ACK;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            cnt <= 4'd0;
                            if (rw) begin
                                shifter <= tx_data;
                                sda_oe  <= ~tx_data[7];
                                state   <= RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shifter <= {shifter[6:0], sda_s};
                            cnt     <= cnt + 4'd1;
                            if (cnt == 4'd7) begin
                                rx_data  <= {shifter[6:0], sda_s};
                                rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && cnt == 4'd8) begin
                            sda_oe <= ~NACK_WRITE;
                            state  <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            cnt    <= 4'd0;
                            state  <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        // cnt counts bits already clocked out by the master.
                        if (scl_rise) begin
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= RD_ACK;
                            end else begin
                                sda_oe  <= ~shifter[6];
                                shifter <= {shifter[6:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && sda_s) begin
                            nack_det <= 1'b1;
                            state    <= IGNORE;
                        end else if (scl_fall) begin
                            shifter <= tx_data;
                            sda_oe  <= ~tx_data[7];
                            cnt     <= 4'd0;
                            state   <= RD_DATA;
                        end
                    end
                    IGNORE: sda_oe <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C target-side responder: the far end of the board's I2C address-probe master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and shifts in the 7-bit address plus R/W bit.
- ACKs on address match, then either receives write bytes (ACKing each) or transmits read bytes supplied by local logic.
- Used to emulate a slave at SLAVE_ADR and to answer the bus-liveness probe (address byte, ACK/NACK check).

Parameters:
- SLAVE_ADR, 7'h68, 7-bit address this block answers to.
- SYNC_STAGES, 2, synchronizer depth on scl_i/sda_i (legal 2..3).
- NACK_WRITE, 1'b0, 1 = NACK every write data byte (address is still ACKed).

Ports:
- clk  in  1  system clock, at least 8x the SCL rate.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  SCL pad input (never driven by this block).
- sda_i  in  1  SDA pad input.
- sda_oe  out  1  1 = pull SDA low (pad is open-drain, pad value 1'b0); 0 = release.
- tx_data  in  8  read byte; sampled in the cycle tx_req is high.
- tx_req  out  1  1-cycle pulse: tx_data is loaded into the shifter.
- rx_data  out  8  last received write byte; valid when rx_valid pulses.
- rx_valid  out  1  1-cycle pulse after the 8th write-data bit.
- start_det  out  1  1-cycle pulse on START or repeated START.
- stop_det  out  1  1-cycle pulse on STOP.
- addr_match  out  1  level, high from address ACK until STOP/START.
- rw  out  1  R/W bit of the current transfer (1 = read), held until next START.
- nack_det  out  1  1-cycle pulse when the master NACKs a read byte.
- busy  out  1  high between START and STOP.

Behaviour:
- Reset values: sda_oe=0, tx_req=0, rx_data=8'h00, rx_valid=0, start_det=0, stop_det=0, addr_match=0, rw=0, nack_det=0, busy=0. State is IDLE, bit counter 0.
- Sync/edges:
  - scl_i and sda_i each pass through SYNC_STAGES flops; reset value of every sync flop is 1.
  - scl_s/sda_s are the synced values; scl_d/sda_d are one cycle later.
  - scl_rise = scl_s&~scl_d; scl_fall = ~scl_s&scl_d.
  - START = scl_s&scl_d&~sda_s&sda_d; STOP = scl_s&scl_d&sda_s&~sda_d.
- START: accepted in any state, including mid-byte; it is the repeated-START case. Effects: state→ADDR, counter=0, addr_match=0, sda_oe=0, busy=1, start_det pulse.
- STOP: accepted in any state. Effects: state→IDLE, sda_oe=0, addr_match=0, busy=0, stop_det pulse.
- Sampling and driving rules:
  - SDA is sampled only on scl_rise.
  - sda_oe changes only on scl_fall, except at START/STOP and reset.
- States:
  - IDLE: ignore everything except START.
  - ADDR: on each scl_rise shift sda_s into the shifter, MSB first, counter++. On the scl_fall after the 8th bit:
    - addr[7:1]==SLAVE_ADR → sda_oe=1, rw=bit0, addr_match=1, →ADDR_ACK.
    - Otherwise → IGNORE with sda_oe=0.
  - ADDR_ACK: on the next scl_fall:
    - rw=0 → sda_oe=0, counter=0, →WR_DATA.
    - rw=1 → tx_req pulse, load tx_data, drive sda_oe=~tx_data[7], →RD_DATA.
  - WR_DATA: shift 8 bits on scl_rise. On the 8th scl_rise: rx_data=shifter, rx_valid pulse in the following cycle. On the next scl_fall: sda_oe=~NACK_WRITE, →WR_ACK.
  - WR_ACK: on scl_fall, sda_oe=0, counter=0, →WR_DATA.
  - RD_DATA:
    - On each scl_fall after the first, drive sda_oe=~shifter bit (next MSB).
    - After the 8th bit's scl_fall, sda_oe=0 (release for the master's ACK), →RD_ACK.
  - RD_ACK: sample sda_s on scl_rise.
    - 0 (ACK): on the next scl_fall pulse tx_req, load the next tx_data, drive its MSB, →RD_DATA.
    - 1 (NACK): pulse nack_det, →IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- Simultaneous events: START/STOP take priority over any scl edge in the same cycle. scl edges and START/STOP cannot coincide logically, but the priority is still required.
- The block never stretches SCL.

Test Plan:
- Probe ACK: master sends START, byte 8'hD1 (8'h68+R), releases SDA. Required: sda_oe=1 for exactly the 9th SCL low/high period; addr_match=1, rw=1; tx_req pulses once at the ACK-ending fall.
- Address miss: byte 8'hA0. Required: sda_oe stays 0 throughout; 9th-bit SDA reads 1 (NACK); state IGNORE; addr_match=0; no tx_req.
- Write: START, 8'hD0, 8'h5A, 8'h3C, STOP. Required: two rx_valid pulses with rx_data 8'h5A then 8'h3C; ACK on all three bytes; stop_det pulse; busy=0.
- Read: START, 8'hD1, tx_data=8'hA5 then 8'h0F; master ACKs byte 1 and NACKs byte 2. Required: SDA sequence 10100101, 00001111; tx_req pulses twice; nack_det pulses once.
- Repeated START mid-write: after 4 data bits, START then 8'hD1. Required: start_det pulse, no rx_valid, address re-ACKed, rw=1.
- Async reset: assert rst_n=0 while sda_oe=1 in ADDR_ACK. Required: sda_oe=0 and all outputs at reset values immediately, without a clock edge.
